uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Transmitter-side bundle between the arbiter (master) and the UART transmitter (slave).
// The arbiter drives configuration, data and request; the transmitter returns the acknowledge.
interface uart_tx_arbiter_if;
    logic        tr_en;
    logic [15:0] comp;
    logic [1:0]  stop_sel;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_req_ack;

    modport master (
        output tr_en, comp, stop_sel, tx_data, tx_req,
        input  tx_req_ack
    );

    modport slave (
        input  tr_en, comp, stop_sel, tx_data, tx_req,
        output tx_req_ack
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte requesters,
// with a per-byte acknowledge timeout and one-cycle done/err pulses per requester.
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int TO_W  = 20
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [15:0]          comp_cfg,
    input  logic [1:0]           stop_cfg,
    input  logic [TO_W-1:0]      to_lim,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    output logic                 busy,
    uart_tx_arbiter_if.master    tx_if
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [IW-1:0]    last_q,   last_d;
    logic [IW-1:0]    grant_q,  grant_d;
    logic [TO_W-1:0]  timer_q,  timer_d;
    logic             tx_req_q, tx_req_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [N_REQ-1:0] done_q,   done_d;
    logic [N_REQ-1:0] err_q,    err_d;
    logic             busy_q,   busy_d;
    logic             tr_en_q;
    logic [15:0]      comp_q,   comp_d;
    logic [1:0]       stop_q,   stop_d;

    logic [7:0]       lane [N_REQ];
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;
    logic             win_vld;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Circular search from last+1; the loop runs downward so the nearest candidate is written last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % N_REQ);
            if (req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        timer_d   = timer_q;
        tx_req_d  = tx_req_q;
        tx_data_d = tx_data_q;
        done_d    = '0;
        err_d     = '0;
        comp_d    = comp_q;
        stop_d    = stop_q;

        if (state_q == S_IDLE) begin
            comp_d = comp_cfg;
            stop_d = stop_cfg;
        end

        if (!en) begin
            state_d  = S_IDLE;
            tx_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_d   = win_idx;
                        tx_data_d = lane[win_idx];
                        tx_req_d  = 1'b1;
                        timer_d   = '0;
                        state_d   = S_REQ;
                    end
                end
                S_REQ: begin
                    if (timer_q != '1)
                        timer_d = timer_q + 1'b1;
                    // Acknowledge has priority over a simultaneous timeout.
                    if (tx_if.tx_req_ack) begin
                        tx_req_d        = 1'b0;
                        done_d[grant_q] = 1'b1;
                        last_d          = grant_q;
                        state_d         = S_REL;
                    end else if ((to_lim != '0) && (timer_q == to_lim - 1'b1)) begin
                        tx_req_d       = 1'b0;
                        err_d[grant_q] = 1'b1;
                        last_d         = grant_q;
                        state_d        = S_REL;
                    end
                end
                S_REL: begin
                    tx_req_d = 1'b0;
                    if (!tx_if.tx_req_ack)
                        state_d = S_IDLE;
                end
                default: begin
                    state_d  = S_IDLE;
                    tx_req_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            last_q    <= IW'(N_REQ - 1);
            grant_q   <= '0;
            timer_q   <= '0;
            tx_req_q  <= 1'b0;
            tx_data_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            tr_en_q   <= 1'b0;
            comp_q    <= '0;
            stop_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            timer_q   <= timer_d;
            tx_req_q  <= tx_req_d;
            tx_data_q <= tx_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            tr_en_q   <= en;
            comp_q    <= comp_d;
            stop_q    <= stop_d;
        end
    end

    assign done           = done_q;
    assign err            = err_q;
    assign busy           = busy_q;
    assign tx_if.tr_en    = tr_en_q;
    assign tx_if.comp     = comp_q;
    assign tx_if.stop_sel = stop_q;
    assign tx_if.tx_data  = tx_data_q;
    assign tx_if.tx_req   = tx_req_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, round-robin order, timeout,
// ack/timeout collision, en abort and reset in the release phase.
module tb_uart_tx_arbiter;
    logic        clk;
    logic        resetn;
    logic        en;
    logic [15:0] comp_cfg;
    logic [1:0]  stop_cfg;
    logic [19:0] to_lim;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  done;
    logic [3:0]  err;
    logic        busy;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.N_REQ(4), .TO_W(20)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .comp_cfg (comp_cfg),
        .stop_cfg (stop_cfg),
        .to_lim   (to_lim),
        .req      (req),
        .req_data (req_data),
        .done     (done),
        .err      (err),
        .busy     (busy),
        .tx_if    (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int ack_dly;
    int ack_cnt = 0;
    int n_done = 0;
    int n_err = 0;
    int n_multi = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: ack rises ack_dly cycles into the request (0 = never), drops once tx_req is low.
    always @(negedge clk) begin
        if (bus.tx_req === 1'b1) begin
            ack_cnt = ack_cnt + 1;
            if (ack_dly != 0 && ack_cnt == ack_dly)
                bus.tx_req_ack = 1'b1;
        end else begin
            ack_cnt = 0;
            bus.tx_req_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            n_done = n_done + $countones(done);
            n_err  = n_err + $countones(err);
            if ($countones(done | err) > 1)
                n_multi = n_multi + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.tx_req !== 1'b1 && n < 400);
        chk("grant_seen", 32'(bus.tx_req), 32'd1);
    endtask

    task automatic wait_done(input int exp_idx, input int exp_n, input bit exp_err);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while ((done | err) == 4'b0 && n < 300);
        $display("xfer idx=%0d lat=%0d done=%b err=%b data=%02h", exp_idx, n, done, err, bus.tx_data);
        chk("xfer_lat", 32'(n), 32'(exp_n));
        chk("xfer_done", 32'(done), exp_err ? 32'd0 : 32'(1 << exp_idx));
        chk("xfer_err", 32'(err), exp_err ? 32'(1 << exp_idx) : 32'd0);
        chk("xfer_txreq", 32'(bus.tx_req), 32'd0);
        chk("xfer_busy", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy !== 1'b0 && n < 50);
        chk("idle", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [6];
        order = '{0, 1, 3, 0, 1, 3};
        resetn   = 1'b0;
        en       = 1'b1;
        req      = 4'b0;
        req_data = 32'h0;
        comp_cfg = 16'h1234;
        stop_cfg = 2'b10;
        to_lim   = 20'd0;
        ack_dly  = 20;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_txreq", 32'(bus.tx_req), 32'd0);
        chk("rst_txdata", 32'(bus.tx_data), 32'd0);
        chk("rst_done", 32'(done | err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tren", 32'(bus.tr_en), 32'd0);
        chk("rst_comp", 32'(bus.comp), 32'd0);
        chk("rst_stop", 32'(bus.stop_sel), 32'd0);

        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("cfg_tren", 32'(bus.tr_en), 32'd1);
        chk("cfg_comp", 32'(bus.comp), 32'h1234);
        chk("cfg_stop", 32'(bus.stop_sel), 32'd2);

        // Single requester, one-cycle grant latency
        @(negedge clk);
        req      = 4'b0001;
        req_data = 32'h0000_00A5;
        @(posedge clk); #1;
        chk("single_txreq", 32'(bus.tx_req), 32'd1);
        chk("single_data", 32'(bus.tx_data), 32'hA5);
        chk("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        req      = 4'b0;
        req_data = 32'h0000_005A;
        comp_cfg = 16'h4321;
        wait_done(0, 20, 1'b0);
        chk("single_hold", 32'(bus.tx_data), 32'hA5);
        chk("single_comp_hold", 32'(bus.comp), 32'h1234);
        @(posedge clk); #1;
        chk("single_busy_fall", 32'(busy), 32'd0);

        // Round-robin with req=1011 held
        do_reset();
        ack_dly  = 3;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            wait_grant();
            chk("rr_data", 32'(bus.tx_data), 32'(8'h10 + order[i]));
            wait_done(order[i], 3, 1'b0);
        end
        @(negedge clk);
        req = 4'b0;
        wait_idle();

        // Timeout on index 1, then the next grant goes to index 2
        @(negedge clk);
        to_lim  = 20'd100;
        ack_dly = 0;
        req     = 4'b0110;
        wait_grant();
        chk("to_data", 32'(bus.tx_data), 32'h11);
        wait_done(1, 100, 1'b1);
        ack_dly = 5;
        wait_grant();
        chk("to_next_data", 32'(bus.tx_data), 32'h12);
        @(negedge clk);
        req = 4'b0;
        wait_done(2, 5, 1'b0);
        wait_idle();

        // Ack arrives on the exact timeout cycle
        @(negedge clk);
        to_lim  = 20'd10;
        ack_dly = 10;
        req     = 4'b0001;
        wait_grant();
        @(negedge clk);
        req = 4'b0;
        wait_done(0, 10, 1'b0);
        wait_idle();

        // en dropped mid-request
        @(negedge clk);
        to_lim  = 20'd0;
        ack_dly = 0;
        req     = 4'b0110;
        wait_grant();
        chk("abort_data", 32'(bus.tx_data), 32'h11);
        repeat (4) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        chk("abort_txreq", 32'(bus.tx_req), 32'd0);
        chk("abort_tren", 32'(bus.tr_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pulse", 32'(done | err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_nogrant", 32'(bus.tx_req), 32'd0);
        @(negedge clk);
        ack_dly = 4;
        en      = 1'b1;
        @(posedge clk); #1;
        chk("abort_regrant", 32'(bus.tx_req), 32'd1);
        chk("abort_regrant_data", 32'(bus.tx_data), 32'h11);
        chk("abort_tren_back", 32'(bus.tr_en), 32'd1);
        @(negedge clk);
        req = 4'b0;
        wait_done(1, 4, 1'b0);
        wait_idle();

        // Reset while in release with ack high
        @(negedge clk);
        ack_dly = 3;
        req     = 4'b0001;
        wait_grant();
        @(negedge clk);
        req = 4'b0;
        wait_done(0, 3, 1'b0);
        resetn = 1'b0;
        #1;
        chk("mrst_txreq", 32'(bus.tx_req), 32'd0);
        chk("mrst_txdata", 32'(bus.tx_data), 32'd0);
        chk("mrst_pulse", 32'(done | err), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_tren", 32'(bus.tr_en), 32'd0);
        chk("mrst_comp", 32'(bus.comp), 32'd0);
        chk("mrst_stop", 32'(bus.stop_sel), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        req    = 4'b1111;
        wait_grant();
        chk("mrst_first_data", 32'(bus.tx_data), 32'h10);
        @(negedge clk);
        req = 4'b0;
        wait_done(0, 3, 1'b0);
        wait_idle();

        chk("total_done", 32'(n_done), 32'd11);
        chk("total_err", 32'(n_err), 32'd1);
        chk("onehot_pulse", 32'(n_multi), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
